// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder
//   Receives the raw PS/2 keyboard stream, deframes it into scancode bytes
//   and folds E0/F0 prefixes into an 11-bit key-event word
//   {toggle, pressed, extended, code[7:0]}. The toggle bit flips once per event.
//
// Ports
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock (asynchronous)
//   ps2_dat    in   raw PS/2 data (asynchronous)
//   ps2_key    out  [10:0] key-event word
//   rx_byte    out  [7:0]  last correctly framed byte
//   rx_strobe  out  one-cycle pulse, rx_byte valid
//   frame_err  out  one-cycle pulse, parity/start/stop/timeout error
module ps2_key_encoder #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 11000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [10:0] ps2_key,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        frame_err
);

    localparam logic [7:0]  FLT_MAX = 8'(FILTER_LEN - 1);
    localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    // index 0 = clock, index 1 = data
    logic [1:0] sync1_q, sync2_q, filt_q, flip;
    logic [7:0] fcnt_q [2];

    state_e      state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [15:0] to_cnt_q;
    logic [7:0]  rx_byte_q;
    logic        rx_strobe_q, frame_err_q;

    logic [10:0] key_q;
    logic        ext_q, brk_q;
    logic [2:0]  skip_q;

    logic clk_edge, clk_fall, dat_f;

    // A filtered signal flips on the FILTER_LEN-th consecutive disagreeing sample
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            flip[i] = (sync2_q[i] != filt_q[i]) && (fcnt_q[i] == FLT_MAX);
        end
    end

    assign clk_edge = flip[0];
    assign clk_fall = flip[0] & filt_q[0];
    assign dat_f    = filt_q[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            filt_q  <= '1;
            for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            sync1_q <= {ps2_dat, ps2_clk};
            sync2_q <= sync1_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (flip[i]) begin
                    fcnt_q[i] <= '0;
                    filt_q[i] <= ~filt_q[i];
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Frame FSM with inactivity timeout
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            rx_byte_q   <= '0;
            rx_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;

            if (clk_edge || state_q == IDLE) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_MAX) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end

            if (state_q != IDLE && !clk_edge && to_cnt_q == TO_MAX - 16'd1) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
            end else if (clk_fall) begin
                case (state_q)
                    IDLE: begin
                        if (!dat_f) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_f, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= dat_f;
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (dat_f && (^{shift_q, par_q})) begin
                            rx_byte_q   <= shift_q;
                            rx_strobe_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Prefix decoder: E1 starts a Pause sequence whose remaining 7 bytes are dropped
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
        end else if (frame_err_q) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
        end else if (rx_strobe_q) begin
            if (skip_q != 3'd0) begin
                skip_q <= skip_q - 3'd1;
            end else begin
                case (rx_byte_q)
                    8'hE0: ext_q  <= 1'b1;
                    8'hF0: brk_q  <= 1'b1;
                    8'hE1: skip_q <= 3'd7;
                    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end
                    default: begin
                        key_q <= {~key_q[10], ~brk_q, ext_q, rx_byte_q};
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ps2_key   = key_q;
    assign rx_byte   = rx_byte_q;
    assign rx_strobe = rx_strobe_q;
    assign frame_err = frame_err_q;

endmodule
